// File: rtl/spi_tx_packetizer.sv
// ---------------------------------------------------------------------------
// spi_tx_packetizer
//
// Store-and-forward packet buffer that sits in front of spi_master_wrapper.
// A tlast-framed AXI-Stream packet is captured into an internal FIFO. Once
// the whole packet is held, the block pulses trigger with num_bytes, streams
// the bytes to the master, then waits for spi_busy to drop before it takes
// the next packet. Packets longer than DEPTH keep their first DEPTH bytes.
// The rest of the packet is accepted and dropped, and trunc_err pulses once.
//
// Optional build macro:
//   SPI_TX_PACKETIZER_STATS_EN - adds saturating 16-bit pkt_count and
//                                trunc_count outputs.
//
// Ports:
//   clk_in         system clock, rising edge
//   rst_in         asynchronous active-low reset
//   s_axis_*       upstream packet stream (tdata/tvalid/tready/tlast)
//   m_axis_*       byte stream to the SPI master (tdata/tvalid/tready/tlast)
//   trigger        one-cycle start pulse to the SPI master
//   num_bytes      transaction length, valid from the trigger cycle onward
//   spi_busy       SPI master busy
//   trunc_err      one-cycle pulse when a packet overflowed the FIFO
//   pkt_count      (stats build) number of trigger pulses, saturating
//   trunc_count    (stats build) number of trunc_err pulses, saturating
//   busy           high whenever the block is not filling
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_FILL    | accepting packet bytes into the FIFO
// S_DISCARD | FIFO full, dropping bytes up to tlast
// S_ARM     | one cycle: trigger pulse, num_bytes valid
// S_SEND    | streaming FIFO contents to the SPI master
// S_WAIT    | waiting for spi_busy low before the next packet
// ---------------------------------------------------------------------------
module spi_tx_packetizer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  trigger,
    output logic [CNT_WIDTH-1:0]  num_bytes,
    input  logic                  spi_busy,
    output logic                  trunc_err,
`ifdef SPI_TX_PACKETIZER_STATS_EN
    output logic [15:0]           pkt_count,
    output logic [15:0]           trunc_count,
`endif
    output logic                  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_FILL,
        S_DISCARD,
        S_ARM,
        S_SEND,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [AW:0]           count, remaining;
    logic                  ready_en;
    logic                  full, empty;
    logic                  in_acc, out_acc;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign in_acc  = s_axis_tvalid && s_axis_tready;
    assign out_acc = m_axis_tvalid && m_axis_tready;
    assign busy    = (state != S_FILL);

    // FIFO head is read combinationally. It is forced to zero outside
    // S_SEND, so the storage (which has no reset) never shows on the port.
    assign m_axis_tdata = (state == S_SEND) ? mem[rd_ptr[AW-1:0]] : '0;

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        trigger       = 1'b0;
        case (state)
            S_FILL: begin
                // ready_en keeps tready low until the first clock after reset.
                s_axis_tready = ready_en && !full;
                if (s_axis_tvalid && ready_en && !full) begin
                    if (s_axis_tlast)
                        state_nxt = S_ARM;
                    else if (count == FULL_CNT - 1'b1)
                        state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                s_axis_tready = ready_en;
                if (s_axis_tvalid && ready_en && s_axis_tlast)
                    state_nxt = S_ARM;
            end
            S_ARM: begin
                trigger   = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                m_axis_tvalid = !empty;
                m_axis_tlast  = (remaining == ONE_CNT);
                if (!empty && m_axis_tready && remaining == ONE_CNT)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!spi_busy)
                    state_nxt = S_FILL;
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= S_FILL;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (state == S_FILL && in_acc)
            mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end

    // num_bytes and remaining are loaded on the edge that enters S_ARM.
    // That way num_bytes is already valid while trigger is high.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            num_bytes <= '0;
            trunc_err <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            trunc_err <= 1'b0;
            if (state == S_FILL && in_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
                if (s_axis_tlast) begin
                    num_bytes <= CNT_WIDTH'(count + 1'b1);
                    remaining <= count + 1'b1;
                end else if (count == FULL_CNT - 1'b1) begin
                    trunc_err <= 1'b1;
                end
            end
            if (state == S_DISCARD && in_acc && s_axis_tlast) begin
                num_bytes <= CNT_WIDTH'(count);
                remaining <= count;
            end
            if (out_acc) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (state == S_WAIT && !spi_busy)
                count <= '0;
        end
    end

`ifdef SPI_TX_PACKETIZER_STATS_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pkt_count   <= '0;
            trunc_count <= '0;
        end else begin
            if (trigger && pkt_count != 16'hFFFF)
                pkt_count <= pkt_count + 16'd1;
            if (trunc_err && trunc_count != 16'hFFFF)
                trunc_count <= trunc_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_tx_packetizer.sv
module tb_spi_tx_packetizer;

    logic        clk_in;
    logic        rst_in;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        trigger;
    logic [31:0] num_bytes;
    logic        spi_busy;
    logic        trunc_err;
    logic        busy;
`ifdef SPI_TX_PACKETIZER_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] trunc_count;
`endif

    spi_tx_packetizer #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(32)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .trigger       (trigger),
        .num_bytes     (num_bytes),
        .spi_busy      (spi_busy),
        .trunc_err     (trunc_err),
`ifdef SPI_TX_PACKETIZER_STATS_EN
        .pkt_count     (pkt_count),
        .trunc_count   (trunc_count),
`endif
        .busy          (busy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int errors = 0;
    int checks = 0;
    int trig_cnt = 0;
    int trunc_cnt = 0;

    logic [7:0] got_data [0:31];
    logic       got_last [0:31];
    int         got_n;
    int         stall_err;
    logic       first_valid;
    logic       push_timeout;

    always @(negedge clk_in) begin
        if (trigger === 1'b1)   trig_cnt++;
        if (trunc_err === 1'b1) trunc_cnt++;
    end

    // Drives len beats first, first+1, ... with tlast on the final beat.
    // Returns at the negedge of the cycle after the final accept.
    task automatic push_pkt(input int len, input logic [7:0] first);
        int i = 0;
        int guard = 0;
        push_timeout = 1'b0;
        while (i < len && guard < 200) begin
            @(negedge clk_in);
            s_axis_tdata  = first + 8'(i);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == len - 1);
            if (s_axis_tready === 1'b1) i++;
            guard++;
        end
        if (i < len) push_timeout = 1'b1;
        @(negedge clk_in);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
    endtask

    // Collects output beats. mode 0: always ready. mode 1: ready follows 1,0,0,1,0,1.
    // Stops after a tlast beat, after max_n beats, or when the budget runs out.
    task automatic pull_pkt(input int mode, input int max_n);
        logic rdy;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic prev_last = 1'b0;
        got_n = 0;
        stall_err = 0;
        first_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_in);
            if (mode == 0) rdy = 1'b1;
            else begin
                case (k % 6)
                    0, 3, 5: rdy = 1'b1;
                    default: rdy = 1'b0;
                endcase
            end
            m_axis_tready = rdy;
            if (k == 0) first_valid = m_axis_tvalid;
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                               m_axis_tlast !== prev_last))
                stall_err++;
            prev_stall = (m_axis_tvalid === 1'b1) && !rdy;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (m_axis_tvalid === 1'b1 && rdy) begin
                got_data[got_n] = m_axis_tdata;
                got_last[got_n] = m_axis_tlast;
                got_n++;
                if (m_axis_tlast === 1'b1 || got_n >= max_n) break;
            end
        end
        @(negedge clk_in);
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
        m_axis_tready = 1'b0; spi_busy = 1'b0;
        #12;
        checks++; if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, trigger, trunc_err, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000",
                {s_axis_tready, m_axis_tvalid, m_axis_tlast, trigger, trunc_err, busy}); end
        checks++; if (num_bytes !== 32'd0 || m_axis_tdata !== 8'h00) begin
            errors++; $display("FAIL reset_data num_bytes=%0d tdata=%h exp 0/00", num_bytes, m_axis_tdata); end
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        checks++; if (s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL reset_release_ready got=%b exp=0", s_axis_tready); end
        @(negedge clk_in);
        checks++; if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL reset_first_clock_ready got=%b exp=1", s_axis_tready); end
    endtask

    task automatic test_basic();
        int t0 = trig_cnt;
        push_pkt(4, 8'hA1);
        checks++; if (push_timeout !== 1'b0) begin errors++; $display("FAIL basic_push_timeout got=1 exp=0"); end
        checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL basic_trigger_latency got=%b exp=1", trigger); end
        checks++; if (num_bytes !== 32'd4) begin errors++; $display("FAIL basic_num_bytes got=%0d exp=4", num_bytes); end
        pull_pkt(0, 32);
        checks++; if (first_valid !== 1'b1) begin errors++; $display("FAIL basic_tvalid_latency got=%b exp=1", first_valid); end
        checks++; if (got_n !== 4) begin errors++; $display("FAIL basic_beats got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_data[i] !== 8'hA1 + 8'(i) || got_last[i] !== (i == 3)) begin
                errors++; $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                                   8'hA1 + 8'(i), (i == 3)); end
        end
        checks++; if (busy !== 1'b1 || s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL basic_wait busy=%b ready=%b exp 1/0", busy, s_axis_tready); end
        @(negedge clk_in);
        checks++; if (busy !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL basic_idle busy=%b ready=%b exp 0/1", busy, s_axis_tready); end
        checks++; if (trig_cnt - t0 !== 1) begin errors++; $display("FAIL basic_trigger_count got=%0d exp=1", trig_cnt - t0); end
    endtask

    task automatic test_stall();
        push_pkt(4, 8'hA1);
        checks++; if (num_bytes !== 32'd4) begin errors++; $display("FAIL stall_num_bytes got=%0d exp=4", num_bytes); end
        pull_pkt(1, 32);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL stall_beats got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_data[i] !== 8'hA1 + 8'(i) || got_last[i] !== (i == 3)) begin
                errors++; $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                                   8'hA1 + 8'(i), (i == 3)); end
        end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_stability got=%0d exp=0", stall_err); end
        @(negedge clk_in);
    endtask

    task automatic test_trunc();
        int e0 = trunc_cnt;
        push_pkt(20, 8'h00);
        checks++; if (push_timeout !== 1'b0) begin errors++; $display("FAIL trunc_push_timeout got=1 exp=0"); end
        checks++; if (trigger !== 1'b1 || num_bytes !== 32'd16) begin
            errors++; $display("FAIL trunc_arm trigger=%b num_bytes=%0d exp 1/16", trigger, num_bytes); end
        checks++; if (trunc_cnt - e0 !== 1) begin errors++; $display("FAIL trunc_err_pulses got=%0d exp=1", trunc_cnt - e0); end
        pull_pkt(0, 32);
        checks++; if (got_n !== 16) begin errors++; $display("FAIL trunc_beats got=%0d exp=16", got_n); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_data[i] !== 8'(i) || got_last[i] !== (i == 15)) begin
                errors++; $display("FAIL trunc_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                                   8'(i), (i == 15)); end
        end
        @(negedge clk_in);
    endtask

    task automatic test_single();
        push_pkt(1, 8'h5A);
        checks++; if (trigger !== 1'b1 || num_bytes !== 32'd1) begin
            errors++; $display("FAIL single_arm trigger=%b num_bytes=%0d exp 1/1", trigger, num_bytes); end
        pull_pkt(0, 32);
        checks++; if (got_n !== 1 || got_data[0] !== 8'h5A || got_last[0] !== 1'b1) begin
            errors++; $display("FAIL single_beat n=%0d data=%h last=%b exp 1/5a/1", got_n, got_data[0], got_last[0]); end
        @(negedge clk_in);
    endtask

    task automatic test_busy_hold();
        int viol = 0;
        spi_busy = 1'b1;
        push_pkt(2, 8'h30);
        pull_pkt(0, 32);
        checks++; if (got_n !== 2 || got_data[1] !== 8'h31) begin
            errors++; $display("FAIL hold_pkt n=%0d last_data=%h exp 2/31", got_n, got_data[1]); end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_in);
            if (s_axis_tready !== 1'b0 || busy !== 1'b1) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL hold_ready_low violations=%0d exp=0", viol); end
        @(negedge clk_in);
        spi_busy = 1'b0;
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL hold_fall_cycle got=%b exp=0", s_axis_tready); end
        @(negedge clk_in);
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL hold_release got=%b exp=1", s_axis_tready); end
        push_pkt(3, 8'h40);
        checks++; if (num_bytes !== 32'd3) begin errors++; $display("FAIL hold_next_num got=%0d exp=3", num_bytes); end
        pull_pkt(0, 32);
        for (int i = 0; i < 3; i++) begin
            checks++; if (got_data[i] !== 8'h40 + 8'(i) || got_last[i] !== (i == 2)) begin
                errors++; $display("FAIL hold_next_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                                   8'h40 + 8'(i), (i == 2)); end
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid();
        int t0;
        push_pkt(4, 8'hB0);
        pull_pkt(0, 2);
        checks++; if (got_n !== 2) begin errors++; $display("FAIL mid_partial got=%0d exp=2", got_n); end
        t0 = trig_cnt;
        rst_in = 1'b0;
        #1;
        checks++; if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, trigger, busy} !== 5'b0 ||
                      num_bytes !== 32'd0 || m_axis_tdata !== 8'h00) begin
            errors++; $display("FAIL mid_reset_outputs ctrl=%b num=%0d data=%h exp 00000/0/00",
                {s_axis_tready, m_axis_tvalid, m_axis_tlast, trigger, busy}, num_bytes, m_axis_tdata); end
        @(negedge clk_in);
        rst_in = 1'b1;
        push_pkt(3, 8'hC0);
        checks++; if (num_bytes !== 32'd3) begin errors++; $display("FAIL mid_new_num got=%0d exp=3", num_bytes); end
        pull_pkt(0, 32);
        checks++; if (got_n !== 3) begin errors++; $display("FAIL mid_new_beats got=%0d exp=3", got_n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got_data[i] !== 8'hC0 + 8'(i) || got_last[i] !== (i == 2)) begin
                errors++; $display("FAIL mid_new_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                                   8'hC0 + 8'(i), (i == 2)); end
        end
        @(negedge clk_in);
        checks++; if (trig_cnt - t0 !== 1) begin errors++; $display("FAIL mid_trigger_count got=%0d exp=1", trig_cnt - t0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_trunc();
        test_single();
        test_busy_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
